pcs_tx_ordered_set_ctrl: RTL
============================

Name: pcs_tx_ordered_set_ctrl

Overview:
- Transmit ordered-set controller for the 1000BASE-X PCS. It sits between the GMII transmit interface and the 8b/10b encoder.
- Each GTX_CLK cycle it selects the octet driven on the encoder's tx_o_set input: /I/ idle pairs, /S/, data, /T/, /R/, or /V/. It also keeps code-group even/odd alignment, per IEEE 802.3 Clause 36.

Parameters:
- PWR_UP_IDLES, 4, number of complete /I/ ordered sets forced after reset before TX_EN is honoured (range 1-15).
- INSERT_I1, 1, when 1 the first idle after /T/R/ is /I1/ (K28.5 D5.6) if tx_rd_pos=1; when 0 always /I2/ (K28.5 D16.2).

Ports:
- GTX_CLK  input  1  transmit clock; all logic on rising edge.
- mr_main_reset  input  1  reset, asynchronous, active-low.
- TX_EN  input  1  GMII transmit enable.
- TX_ER  input  1  GMII transmit error.
- TXD  input  8  GMII transmit data.
- tx_rd_pos  input  1  encoder running disparity after the last code group (1 = positive).
- tx_o_set  output  8  octet to encoder.
- tx_o_set_k  output  1  1 = tx_o_set is a K code group.
- tx_even  output  1  1 = the current tx_o_set occupies an even position.
- transmitting  output  1  1 from /S/ through the last /R/ inclusive.

Behaviour:
- Reset (mr_main_reset=0, async): tx_o_set=8'hBC, tx_o_set_k=1, tx_even=1, transmitting=0, state=IDLE_K, power-up counter=0.
- All outputs are registered. Fixed latency of 1 cycle: GMII sampled at edge n appears on tx_o_set after edge n.
- tx_even toggles every cycle unconditionally. Alignment is maintained only by the state sequencing below.
- Octets:
  - K28.5=BC(K), D16.2=50(D), D5.6=C5(D)
  - /S/=K27.7=FB(K), /T/=K29.7=FD(K), /R/=K23.7=F7(K), /V/=K30.7=FE(K)
- States and transitions:
  - IDLE_K: emit BC (even slot only) -> IDLE_D.
  - IDLE_D: emit D16.2. Emit C5 instead only if INSERT_I1=1, this is the first idle after END_R, and tx_rd_pos=1. Increments the power-up counter until it reaches PWR_UP_IDLES.
  - Leaving IDLE_D: if sampled TX_EN=1, the counter is saturated, and the next slot is even -> START; else -> IDLE_K.
  - TX_EN=1 sampled while in IDLE_K: the pending D slot is still emitted as the idle's D octet, and START follows. The first GMII octet is consumed (preamble shortened by one octet).
  - START: emit FB (its octet replaces the sampled TXD octet) -> DATA.
  - DATA: emit TXD (K=0) while TX_EN=1.
  - Leaving DATA: the first sample with TX_EN=0 -> END_T.
  - END_T: emit FD -> END_R1.
  - END_R1: emit F7. If the next slot is even -> IDLE_K, else -> END_R2.
  - END_R2: emit F7 -> IDLE_K.
  - transmitting clears on the edge that enters IDLE_K.
- TX_EN=1 while in END_T/END_R1/END_R2: ignored until IDLE_D is reached. Bench keeps an inter-packet gap of at least 4 cycles.
- TX_EN sampled 1 before the power-up counter saturates: the frame is dropped entirely; the controller stays in idle until TX_EN deasserts.
- Reset asserted mid-frame: immediate return to reset values. No /T/ is emitted.

Optional Feature:
- Macro: PCS_TX_ERR_PROP_EN.
- Defined:
  - TX_EN=1 and TX_ER=1 in DATA: emit FE (K) in place of TXD.
  - TX_EN=0, TX_ER=1, TXD=8'h0F in END_R1/END_R2 or IDLE_K: emit F7 (carrier extend) and hold in END_R1, with the normal even-slot exit when the extension ends.
- Not defined: TX_ER is ignored; no FE is ever emitted.

Test Plan:
- Reset released, TX_EN=0 for 20 cycles -> BC,50 alternating starting BC with tx_even=1; transmitting=0.
- After power-up, TX_EN asserted aligned to an even slot with TXD=55,55,D5,01,02,03 -> tx_o_set FB,55,D5,01,02,03 one cycle later, then FD,F7, then F7 or BC so that BC lands on tx_even=1.
- TX_EN asserted on an odd slot -> one extra D16.2 (50), then FB replacing the second octet; data keeps latency 1.
- Frame with an even data count vs. an odd data count -> /T/R/ vs /T/R/R/; the next BC always has tx_even=1. With tx_rd_pos=1 and INSERT_I1=1 the first idle D octet is C5, otherwise 50.
- TX_EN asserted 2 cycles after reset release (PWR_UP_IDLES=4) -> no FB emitted for that frame; idles continue.
- Reset pulsed low during DATA -> tx_o_set=BC, tx_o_set_k=1, transmitting=0 immediately. With PCS_TX_ERR_PROP_EN defined: TX_ER=1 mid-frame -> FE emitted in that octet.

Source files
------------

// File: rtl/pcs_tx_ordered_set_ctrl.sv
// ---------------------------------------------------------------------------
// pcs_tx_ordered_set_ctrl
//
// Transmit ordered-set controller for a 1000BASE-X PCS. It sits between the
// GMII transmit interface and the 8b/10b encoder. Each GTX_CLK cycle it picks
// the octet for the encoder: idle pairs (/I1/ or /I2/), /S/, data, /T/, /R/
// or /V/. It also keeps /K28.5/ on even code-group positions.
//
// Ports:
//   GTX_CLK        in   transmit clock, rising edge
//   mr_main_reset  in   asynchronous active-low reset
//   TX_EN          in   GMII transmit enable
//   TX_ER          in   GMII transmit error (used only with PCS_TX_ERR_PROP_EN)
//   TXD[7:0]       in   GMII transmit data
//   tx_rd_pos      in   encoder running disparity, 1 = positive
//   tx_o_set[7:0]  out  octet to the encoder (registered)
//   tx_o_set_k     out  1 = tx_o_set is a K code group
//   tx_even        out  1 = tx_o_set occupies an even position
//   transmitting   out  1 from /S/ through the last /R/
//
// Parameters:
//   PWR_UP_IDLES   complete /I/ sets forced after reset before TX_EN counts (1-15)
//   INSERT_I1      1 = first idle after /T/R/ is /I1/ when disparity is positive
//
// Optional feature macro: PCS_TX_ERR_PROP_EN
//   Defined: TX_ER in a frame emits /V/; TX_EN=0, TX_ER=1, TXD=0F after the
//   frame end or in IDLE_K emits /R/ carrier extension.
//   Undefined: TX_ER is ignored.
//
// The current FSM state is r_state; the enum names are the state names.
// Handshake: none. GMII is sampled every rising edge and the chosen octet
// appears on tx_o_set one cycle later; there is no back-pressure.
// ---------------------------------------------------------------------------
module pcs_tx_ordered_set_ctrl #(
    parameter int PWR_UP_IDLES = 4,
    parameter int INSERT_I1    = 1
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [7:0] TXD,
    input  logic       tx_rd_pos,
    output logic [7:0] tx_o_set,
    output logic       tx_o_set_k,
    output logic       tx_even,
    output logic       transmitting
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] K27_7 = 8'hFB;   // /S/
    localparam logic [7:0] K29_7 = 8'hFD;   // /T/
    localparam logic [7:0] K23_7 = 8'hF7;   // /R/
    localparam logic [7:0] K30_7 = 8'hFE;   // /V/
    localparam logic [3:0] PWR_SAT = 4'(PWR_UP_IDLES);

    typedef enum logic [2:0] {
        IDLE_K = 3'd0,
        IDLE_D = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        END_T  = 3'd4,
        END_R1 = 3'd5,
        END_R2 = 3'd6
    } state_t;

    state_t     r_state;
    logic [7:0] r_o_set;
    logic       r_k;
    logic       r_even;
    logic       r_tx;
    logic [3:0] r_cnt;
    logic       r_drop;      // frame seen before power-up idles finished
    logic       r_after_r;   // IDLE_K directly follows an /R/

    state_t     w_next;
    logic [7:0] w_o_set;
    logic       w_k;
    logic       w_sat;
    logic       w_idle;
    logic       w_ext;
    logic       w_verr;
    logic       w_drop_nxt;

    assign w_sat  = (r_cnt == PWR_SAT);
    assign w_idle = (r_state == IDLE_K) || (r_state == IDLE_D);

`ifdef PCS_TX_ERR_PROP_EN
    assign w_ext  = !TX_EN && TX_ER && (TXD == 8'h0F);
    assign w_verr = TX_ER;
`else
    logic w_unused_tx_er;
    assign w_unused_tx_er = TX_ER;
    assign w_ext  = 1'b0;
    assign w_verr = 1'b0;
`endif

    // A frame that starts before the power-up idles finish is discarded in
    // full, so the drop flag is held until TX_EN is seen low.
    always_comb begin
        w_drop_nxt = r_drop;
        if (!TX_EN) begin
            w_drop_nxt = 1'b0;
        end else if (w_idle && !w_sat) begin
            w_drop_nxt = 1'b1;
        end
    end

    always_comb begin
        w_next  = IDLE_K;
        w_o_set = K28_5;
        w_k     = 1'b1;
        case (r_state)
            IDLE_K: begin
                if (w_ext) begin
                    w_next  = END_R1;
                    w_o_set = K23_7;
                end else begin
                    // TX_EN seen here does not cut the idle short: its D
                    // octet still goes out and START is decided on exit.
                    w_next = IDLE_D;
                    w_k    = 1'b0;
                    if ((INSERT_I1 != 0) && r_after_r && tx_rd_pos) begin
                        w_o_set = D5_6;
                    end else begin
                        w_o_set = D16_2;
                    end
                end
            end
            IDLE_D: begin
                if (TX_EN && w_sat && !r_drop && !r_even) begin
                    w_next  = START;
                    w_o_set = K27_7;
                end
            end
            START, DATA: begin
                if (TX_EN) begin
                    w_next = DATA;
                    if (w_verr) begin
                        w_o_set = K30_7;
                    end else begin
                        w_o_set = TXD;
                        w_k     = 1'b0;
                    end
                end else begin
                    w_next  = END_T;
                    w_o_set = K29_7;
                end
            end
            END_T: begin
                w_next  = END_R1;
                w_o_set = K23_7;
            end
            END_R1: begin
                if (w_ext) begin
                    w_next  = END_R1;
                    w_o_set = K23_7;
                end else if (r_even) begin
                    // Next slot is odd: pad one more /R/ so K28.5 lands even.
                    w_next  = END_R2;
                    w_o_set = K23_7;
                end
            end
            END_R2: begin
                if (w_ext) begin
                    w_next  = END_R1;
                    w_o_set = K23_7;
                end
            end
            default: begin
                w_next = IDLE_K;
            end
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state   <= IDLE_K;
            r_o_set   <= K28_5;
            r_k       <= 1'b1;
            r_even    <= 1'b1;
            r_tx      <= 1'b0;
            r_cnt     <= 4'd0;
            r_drop    <= 1'b0;
            r_after_r <= 1'b0;
        end else begin
            r_state <= w_next;
            r_o_set <= w_o_set;
            r_k     <= w_k;
            r_even  <= ~r_even;
            r_tx    <= (w_next != IDLE_K) && (w_next != IDLE_D);
            r_drop  <= w_drop_nxt;
            if ((r_state == IDLE_D) && !w_sat) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_next == IDLE_K) begin
                r_after_r <= (r_state == END_R1) || (r_state == END_R2);
            end else if (w_next == IDLE_D) begin
                r_after_r <= 1'b0;
            end
        end
    end

    assign tx_o_set     = r_o_set;
    assign tx_o_set_k   = r_k;
    assign tx_even      = r_even;
    assign transmitting = r_tx;

endmodule
